iob_nesctrl_evq: RTL

Button-event queue for the two-pad NES controller interface. Consumes the parallel 16-bit controller snapshots produced by the NES controller block. Debounces each pad's 8 button bits over consecutive snapshots and converts every debounced press or release into a 5-bit event. Events are buffered in a FIFO and read by the CPU-side logic over a valid/ready handshake.

---
 rtl/iob_nesctrl_evq_if.sv | 25 ++
 rtl/iob_nesctrl_evq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/iob_nesctrl_evq_if.sv
`default_nettype none
// ============================================================================
// Module      : iob_nesctrl_evq_if
// Description : Event stream handshake between the button-event queue and
//               its consumer (show-ahead valid/ready, 5-bit event payload).
// Revision    : 1.0 - initial release
// ============================================================================
interface iob_nesctrl_evq_if;
    logic       ev_valid;
    logic [4:0] ev_data;
    logic       ev_ready;

    modport master (
        output ev_valid,
        output ev_data,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_data,
        output ev_ready
    );
endinterface
`default_nettype wire

// File: rtl/iob_nesctrl_evq.sv
`default_nettype none
// ============================================================================
// Module      : iob_nesctrl_evq
// Description : Debounces two NES pads and queues every debounced press or
//               release as a {pad, pressed, button} event in a small FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_nesctrl_evq #(
    parameter int DEBOUNCE = 2,
    parameter int FIFO_AW  = 3
) (
    input  wire logic               clk,
    input  wire logic               arst_n,
    input  wire logic               sample_en,
    input  wire logic [15:0]        ctrl1_data,
    input  wire logic [15:0]        ctrl2_data,
    iob_nesctrl_evq_if.master       ev,
    output logic      [FIFO_AW:0]   level,
    output logic      [7:0]         stable1,
    output logic      [7:0]         stable2,
    output logic                    lost,
    input  wire logic               lost_clr
);

    localparam logic [3:0]       c_deb   = 4'(DEBOUNCE);
    localparam logic [3:0]       c_cnt_max = 4'hF;
    localparam int               c_depth_i = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] c_depth = (FIFO_AW+1)'(c_depth_i);

    // Debounce state, index 0 = pad 1, index 1 = pad 2
    logic [1:0][7:0] r_cand;
    logic [1:0][3:0] r_cnt;
    logic [1:0][7:0] r_stable;
    logic [15:0]     r_pending;
    logic            r_lost;

    logic [4:0]         r_mem [c_depth_i];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ev_valid;
    logic [4:0]         r_ev_data;

    logic [1:0][7:0]    w_raw;
    logic [1:0][7:0]    w_cand_nxt;
    logic [1:0][3:0]    w_cnt_nxt;
    logic [1:0][7:0]    w_stable_nxt;
    logic [15:0]        w_stable_cur;
    logic [15:0]        w_chg;
    logic [3:0]         w_idx;
    logic [15:0]        w_pop;
    logic               w_push;
    logic [4:0]         w_push_data;
    logic               w_full;
    logic               w_rd;
    logic [FIFO_AW:0]   w_count_nxt;
    logic [FIFO_AW-1:0] w_rptr_nxt;
    logic [4:0]         w_head_nxt;
    logic               w_unused_hi;

    assign w_raw        = {ctrl2_data[7:0], ctrl1_data[7:0]};
    assign w_unused_hi  = ^{ctrl1_data[15:8], ctrl2_data[15:8]};
    assign w_stable_cur = r_stable;

    always_comb begin
        w_cand_nxt   = r_cand;
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        if (sample_en) begin
            for (int p = 0; p < 2; p++) begin
                if (w_raw[p] == r_cand[p]) begin
                    w_cnt_nxt[p] = (r_cnt[p] == c_cnt_max) ? c_cnt_max : r_cnt[p] + 4'd1;
                end else begin
                    w_cand_nxt[p] = w_raw[p];
                    w_cnt_nxt[p]  = 4'd1;
                end
                if (w_cnt_nxt[p] >= c_deb) begin
                    w_stable_nxt[p] = w_cand_nxt[p];
                end
            end
        end
    end

    assign w_chg = w_stable_nxt ^ r_stable;

    // Lowest pending index wins; descending loop lets lower bits override
    always_comb begin
        w_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    assign w_full      = (r_count == c_depth);
    assign w_push      = (r_pending != 16'd0) && !w_full;
    assign w_pop       = w_push ? (16'd1 << w_idx) : 16'd0;
    assign w_push_data = {w_idx[3], w_stable_cur[w_idx], w_idx[2:0]};
    assign w_rd        = r_ev_valid & ev.ev_ready;
    assign w_rptr_nxt  = r_rptr + FIFO_AW'(w_rd);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_rd})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Head register is preloaded so ev_data never depends on ev_ready
    always_comb begin
        w_head_nxt = 5'd0;
        if (w_count_nxt != '0) begin
            if (w_push && ((r_count - (FIFO_AW+1)'(w_rd)) == '0)) begin
                w_head_nxt = w_push_data;
            end else begin
                w_head_nxt = r_mem[w_rptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cand     <= '0;
            r_cnt      <= '0;
            r_stable   <= '0;
            r_pending  <= '0;
            r_lost     <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ev_valid <= 1'b0;
            r_ev_data  <= '0;
        end else begin
            r_cand    <= w_cand_nxt;
            r_cnt     <= w_cnt_nxt;
            r_stable  <= w_stable_nxt;
            r_pending <= (r_pending & ~w_pop) ^ w_chg;
            if ((w_chg & r_pending & ~w_pop) != 16'd0) begin
                r_lost <= 1'b1;
            end else if (lost_clr) begin
                r_lost <= 1'b0;
            end
            r_wptr     <= r_wptr + FIFO_AW'(w_push);
            r_rptr     <= w_rptr_nxt;
            r_count    <= w_count_nxt;
            r_ev_valid <= (w_count_nxt != '0);
            r_ev_data  <= w_head_nxt;
        end
    end

    assign ev.ev_valid = r_ev_valid;
    assign ev.ev_data  = r_ev_data;
    assign level       = r_count;
    assign stable1     = r_stable[0];
    assign stable2     = r_stable[1];
    assign lost        = r_lost;

endmodule
`default_nettype wire
